// File: rtl/input_stream_loader_pkg.sv
// Shared types and stream framing constants for the input stream loader.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    NODES,
    LEAVES,
    QUERIES
  } state_e;

  localparam int unsigned PATCH_SIZE_DEF   = 5;
  localparam int unsigned NODE_WORDS       = 2;
  localparam int unsigned LEAF_PATCH_WORDS = PATCH_SIZE_DEF + 1;
  localparam int unsigned QUERY_WORDS      = PATCH_SIZE_DEF;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/input_stream_loader_patch_deserializer.sv
// Shift register that assembles PATCH_SIZE stream words (word0 ends in LSBs),
// with a word counter that also spans the trailing index word of a leaf patch.
module patch_deserializer #(
  parameter int unsigned DATA_WIDTH = 11,
  parameter int unsigned PATCH_SIZE = 5,
  parameter int unsigned MAX_WORDS  = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clr_i,
  input  logic                             en_i,
  input  logic                             long_i,
  input  logic [DATA_WIDTH-1:0]            word_i,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0] patch_o,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0] patch_nxt_o,
  output logic                             last_o
);

  localparam int unsigned PW = PATCH_SIZE * DATA_WIDTH;
  localparam int unsigned CW = $clog2(MAX_WORDS);

  logic [CW-1:0] wcnt_q;
  logic [PW-1:0] patch_q;
  logic [CW-1:0] last_idx;

  assign last_idx    = long_i ? CW'(MAX_WORDS - 1) : CW'(PATCH_SIZE - 1);
  assign last_o      = en_i && (wcnt_q == last_idx);
  assign patch_nxt_o = {word_i, patch_q[PW-1:DATA_WIDTH]};
  assign patch_o     = patch_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q  <= '0;
      patch_q <= '0;
    end else if (clr_i) begin
      wcnt_q  <= '0;
      patch_q <= '0;
    end else if (en_i) begin
      // Words past PATCH_SIZE (the leaf index) bypass the shift register.
      if (wcnt_q < CW'(PATCH_SIZE)) patch_q <= patch_nxt_o;
      wcnt_q <= last_o ? '0 : wcnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/input_stream_loader.sv
// Deserializes the FIFO word stream into internal-node, leaf-patch and
// query-patch memory writes; a kdtree load runs nodes, leaves, then queries.
module input_stream_loader
  import loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 11,
  parameter int unsigned IDX_WIDTH   = 9,
  parameter int unsigned DIM_WIDTH   = 3,
  parameter int unsigned PATCH_SIZE  = PATCH_SIZE_DEF,
  parameter int unsigned LEAF_SIZE   = 8,
  parameter int unsigned NUM_LEAVES  = 64,
  parameter int unsigned NUM_QUERYS  = 494,
  parameter int unsigned LEAF_ADDRW  = $clog2(NUM_LEAVES),
  parameter int unsigned QUERY_ADDRW = $clog2(NUM_QUERYS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load_kdtree,
  input  logic                             load_query,
  input  logic [DATA_WIDTH-1:0]            fifo_rdata,
  input  logic                             fifo_rempty_n,
  output logic                             fifo_deq,
  output logic                             node_wen,
  output logic [LEAF_ADDRW-1:0]            node_waddr,
  output logic [DIM_WIDTH-1:0]             node_wdim,
  output logic [DATA_WIDTH-1:0]            node_wmedian,
  output logic                             leaf_wen,
  output logic [LEAF_ADDRW-1:0]            leaf_waddr,
  output logic [$clog2(LEAF_SIZE)-1:0]     leaf_wsel,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0] leaf_wpatch,
  output logic [IDX_WIDTH-1:0]             leaf_widx,
  output logic                             query_wen,
  output logic [QUERY_ADDRW-1:0]           query_waddr,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0] query_wpatch,
  output logic                             busy,
  output logic                             load_done
);

  localparam int unsigned NUM_NODES  = NUM_LEAVES - 1;
  localparam int unsigned SELW       = $clog2(LEAF_SIZE);
  localparam int unsigned PW         = PATCH_SIZE * DATA_WIDTH;
  localparam int unsigned NPW        = cnt_w(NODE_WORDS);
  localparam int unsigned LEAF_WORDS = PATCH_SIZE + (LEAF_PATCH_WORDS - QUERY_WORDS);

  state_e                 state_q;
  logic [NPW-1:0]         node_ph_q;
  logic [DIM_WIDTH-1:0]   dim_q;
  logic [LEAF_ADDRW-1:0]  node_cnt_q;
  logic [LEAF_ADDRW-1:0]  leaf_cnt_q;
  logic [SELW-1:0]        slot_cnt_q;
  logic [QUERY_ADDRW-1:0] query_cnt_q;

  logic          ds_en;
  logic          ds_last;
  logic [PW-1:0] ds_patch;
  logic [PW-1:0] ds_patch_nxt;

  assign busy     = (state_q != IDLE);
  assign fifo_deq = busy && fifo_rempty_n;
  assign ds_en    = fifo_deq && ((state_q == LEAVES) || (state_q == QUERIES));

  patch_deserializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .PATCH_SIZE (PATCH_SIZE),
    .MAX_WORDS  (LEAF_WORDS)
  ) u_deser (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (state_q == IDLE),
    .en_i        (ds_en),
    .long_i      (state_q == LEAVES),
    .word_i      (fifo_rdata),
    .patch_o     (ds_patch),
    .patch_nxt_o (ds_patch_nxt),
    .last_o      (ds_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      node_ph_q    <= '0;
      dim_q        <= '0;
      node_cnt_q   <= '0;
      leaf_cnt_q   <= '0;
      slot_cnt_q   <= '0;
      query_cnt_q  <= '0;
      node_wen     <= 1'b0;
      node_waddr   <= '0;
      node_wdim    <= '0;
      node_wmedian <= '0;
      leaf_wen     <= 1'b0;
      leaf_waddr   <= '0;
      leaf_wsel    <= '0;
      leaf_wpatch  <= '0;
      leaf_widx    <= '0;
      query_wen    <= 1'b0;
      query_waddr  <= '0;
      query_wpatch <= '0;
      load_done    <= 1'b0;
    end else begin
      node_wen  <= 1'b0;
      leaf_wen  <= 1'b0;
      query_wen <= 1'b0;
      load_done <= 1'b0;
      case (state_q)
        IDLE: begin
          node_ph_q   <= '0;
          node_cnt_q  <= '0;
          leaf_cnt_q  <= '0;
          slot_cnt_q  <= '0;
          query_cnt_q <= '0;
          if (load_kdtree)     state_q <= NODES;
          else if (load_query) state_q <= QUERIES;
        end
        NODES: if (fifo_deq) begin
          if (node_ph_q == NPW'(NODE_WORDS - 1)) begin
            node_wen     <= 1'b1;
            node_waddr   <= node_cnt_q;
            node_wdim    <= dim_q;
            node_wmedian <= fifo_rdata;
            node_ph_q    <= '0;
            if (node_cnt_q == LEAF_ADDRW'(NUM_NODES - 1)) begin
              node_cnt_q <= '0;
              state_q    <= LEAVES;
            end else begin
              node_cnt_q <= node_cnt_q + LEAF_ADDRW'(1);
            end
          end else begin
            dim_q     <= fifo_rdata[DIM_WIDTH-1:0];
            node_ph_q <= node_ph_q + NPW'(1);
          end
        end
        LEAVES: if (ds_last) begin
          // Index word is the live FIFO head; the patch register already holds all data words.
          leaf_wen    <= 1'b1;
          leaf_waddr  <= leaf_cnt_q;
          leaf_wsel   <= slot_cnt_q;
          leaf_wpatch <= ds_patch;
          leaf_widx   <= fifo_rdata[IDX_WIDTH-1:0];
          if (slot_cnt_q == SELW'(LEAF_SIZE - 1)) begin
            slot_cnt_q <= '0;
            if (leaf_cnt_q == LEAF_ADDRW'(NUM_LEAVES - 1)) begin
              leaf_cnt_q <= '0;
              state_q    <= QUERIES;
            end else begin
              leaf_cnt_q <= leaf_cnt_q + LEAF_ADDRW'(1);
            end
          end else begin
            slot_cnt_q <= slot_cnt_q + SELW'(1);
          end
        end
        QUERIES: if (ds_last) begin
          query_wen    <= 1'b1;
          query_waddr  <= query_cnt_q;
          query_wpatch <= ds_patch_nxt;
          if (query_cnt_q == QUERY_ADDRW'(NUM_QUERYS - 1)) begin
            query_cnt_q <= '0;
            load_done   <= 1'b1;
            state_q     <= IDLE;
          end else begin
            query_cnt_q <= query_cnt_q + QUERY_ADDRW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_stream_loader.sv
// Scoreboard bench for input_stream_loader: a queue-backed FIFO feeds the DUT,
// expected writes are queued as words are generated and popped on each strobe.
module tb_input_stream_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_kdtree, load_query;
  logic [10:0]  fifo_rdata;
  logic         fifo_rempty_n;
  logic         fifo_deq;
  logic         node_wen;
  logic [5:0]   node_waddr;
  logic [2:0]   node_wdim;
  logic [10:0]  node_wmedian;
  logic         leaf_wen;
  logic [5:0]   leaf_waddr;
  logic [2:0]   leaf_wsel;
  logic [54:0]  leaf_wpatch;
  logic [8:0]   leaf_widx;
  logic         query_wen;
  logic [8:0]   query_waddr;
  logic [54:0]  query_wpatch;
  logic         busy, load_done;

  input_stream_loader #(
    .DATA_WIDTH (11),
    .IDX_WIDTH  (9),
    .DIM_WIDTH  (3),
    .PATCH_SIZE (5),
    .LEAF_SIZE  (8),
    .NUM_LEAVES (64),
    .NUM_QUERYS (494)
  ) dut (
    .clk (clk), .rst (rst),
    .load_kdtree (load_kdtree), .load_query (load_query),
    .fifo_rdata (fifo_rdata), .fifo_rempty_n (fifo_rempty_n), .fifo_deq (fifo_deq),
    .node_wen (node_wen), .node_waddr (node_waddr), .node_wdim (node_wdim),
    .node_wmedian (node_wmedian),
    .leaf_wen (leaf_wen), .leaf_waddr (leaf_waddr), .leaf_wsel (leaf_wsel),
    .leaf_wpatch (leaf_wpatch), .leaf_widx (leaf_widx),
    .query_wen (query_wen), .query_waddr (query_waddr), .query_wpatch (query_wpatch),
    .busy (busy), .load_done (load_done)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [5:0] addr; logic [2:0] dim; logic [10:0] med; } node_t;
  typedef struct packed { logic [5:0] addr; logic [2:0] sel; logic [54:0] patch; logic [8:0] idx; } leaf_t;
  typedef struct packed { logic [8:0] addr; logic [54:0] patch; } query_t;
  typedef struct packed { logic [10:0] w0, w1; logic [2:0] edim; logic [10:0] emed; } nvec_t;
  typedef struct packed { logic [5:0][10:0] w; logic [54:0] epatch; logic [8:0] eidx; } lvec_t;

  nvec_t ntab [4];
  lvec_t ltab [4];

  logic [10:0] fifo_q [$];
  node_t  exp_node  [$];
  leaf_t  exp_leaf  [$];
  query_t exp_query [$];

  int tests = 0, fails = 0;
  int cyc = 0, start_cyc = 0;
  int popped = 0, deq_viol = 0;
  int n_node, n_leaf, n_query, n_done;
  int first_node_rel, first_leaf_rel, first_query_rel, done_rel;
  bit stall_en = 1'b0;
  bit stall, deq_n;

  logic [162:0] all_out;
  assign all_out = {fifo_deq, node_wen, node_waddr, node_wdim, node_wmedian,
                    leaf_wen, leaf_waddr, leaf_wsel, leaf_wpatch, leaf_widx,
                    query_wen, query_waddr, query_wpatch, busy, load_done};

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // FIFO model: show-ahead head word, popped one step after a sampled fifo_deq.
  initial begin
    fifo_rempty_n = 1'b0;
    fifo_rdata    = '0;
    forever begin
      @(negedge clk);
      deq_n = fifo_deq;
      if (fifo_deq && !fifo_rempty_n) deq_viol++;
      @(posedge clk);
      #1;
      if (deq_n && fifo_q.size() > 0) begin
        void'(fifo_q.pop_front());
        popped++;
      end
      stall         = stall_en && ($urandom_range(0, 1) == 0);
      fifo_rempty_n = (fifo_q.size() > 0) && !stall;
      fifo_rdata    = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end
  end

  // Write monitor / scoreboard.
  always @(negedge clk) begin
    int rel;
    node_t ne;
    leaf_t le;
    query_t qe;
    rel = cyc - start_cyc - 1;
    if (node_wen) begin
      if (n_node == 0) first_node_rel = rel;
      n_node++;
      if (exp_node.size() == 0) begin
        tests++; fails++;
        $display("FAIL node_unexpected: got write addr %0d, expected none", node_waddr);
      end else begin
        ne = exp_node.pop_front();
        chk("node_write", {node_waddr, node_wdim, node_wmedian}, ne);
      end
    end
    if (leaf_wen) begin
      if (n_leaf == 0) first_leaf_rel = rel;
      n_leaf++;
      if (exp_leaf.size() == 0) begin
        tests++; fails++;
        $display("FAIL leaf_unexpected: got write addr %0d sel %0d, expected none", leaf_waddr, leaf_wsel);
      end else begin
        le = exp_leaf.pop_front();
        chk("leaf_write", {leaf_waddr, leaf_wsel, leaf_wpatch, leaf_widx}, le);
      end
    end
    if (query_wen) begin
      if (n_query == 0) first_query_rel = rel;
      n_query++;
      if (exp_query.size() == 0) begin
        tests++; fails++;
        $display("FAIL query_unexpected: got write addr %0d, expected none", query_waddr);
      end else begin
        qe = exp_query.pop_front();
        chk("query_write", {query_waddr, query_wpatch}, qe);
      end
    end
    if (load_done) begin
      n_done++;
      done_rel = rel;
      chk("done_with_last_query", {query_wen, query_waddr}, {1'b1, 9'd493});
    end
  end

  task automatic build(input bit kd);
    logic [10:0] w, w0, w1;
    logic [54:0] p;
    fifo_q.delete(); exp_node.delete(); exp_leaf.delete(); exp_query.delete();
    popped = 0; deq_viol = 0;
    if (kd) begin
      for (int i = 0; i < 63; i++) begin
        if (i < 4) begin
          w0 = ntab[i].w0; w1 = ntab[i].w1;
          exp_node.push_back({6'(i), ntab[i].edim, ntab[i].emed});
        end else begin
          w0 = 11'($urandom_range(0, 2047)); w1 = 11'($urandom_range(0, 2047));
          exp_node.push_back({6'(i), w0[2:0], w1});
        end
        fifo_q.push_back(w0); fifo_q.push_back(w1);
      end
      for (int k = 0; k < 512; k++) begin
        if (k < 4) begin
          for (int j = 0; j < 6; j++) fifo_q.push_back(ltab[k].w[j]);
          exp_leaf.push_back({6'(k / 8), 3'(k % 8), ltab[k].epatch, ltab[k].eidx});
        end else begin
          p = '0;
          for (int j = 0; j < 5; j++) begin
            w = 11'($urandom_range(0, 2047));
            p[j*11 +: 11] = w;
            fifo_q.push_back(w);
          end
          w = 11'($urandom_range(0, 2047));
          fifo_q.push_back(w);
          exp_leaf.push_back({6'(k / 8), 3'(k % 8), p, w[8:0]});
        end
      end
    end
    for (int q = 0; q < 494; q++) begin
      p = '0;
      for (int j = 0; j < 5; j++) begin
        w = 11'($urandom_range(0, 2047));
        p[j*11 +: 11] = w;
        fifo_q.push_back(w);
      end
      exp_query.push_back({9'(q), p});
    end
  endtask

  task automatic run(input string tag, input bit kd, input bit poke,
                     input int en, input int el, input int eq,
                     input int fn, input int fl, input int fq, input int dn);
    n_node = 0; n_leaf = 0; n_query = 0; n_done = 0;
    first_node_rel = -1; first_leaf_rel = -1; first_query_rel = -1; done_rel = -1;
    repeat (2) @(negedge clk);
    start_cyc = cyc;
    if (kd) load_kdtree = 1'b1; else load_query = 1'b1;
    @(negedge clk);
    load_kdtree = 1'b0; load_query = 1'b0;
    for (int i = 0; i < 40000; i++) begin
      load_kdtree = (poke && i == 50);
      @(negedge clk);
      if (n_done != 0) break;
    end
    load_kdtree = 1'b0;
    repeat (4) @(negedge clk);
    chk({tag, "_node_count"},  n_node,  en);
    chk({tag, "_leaf_count"},  n_leaf,  el);
    chk({tag, "_query_count"}, n_query, eq);
    chk({tag, "_done_count"},  n_done,  1);
    chk({tag, "_words_left"},  fifo_q.size(), 0);
    chk({tag, "_busy_after"},  busy, 1'b0);
    chk({tag, "_deq_while_empty"}, deq_viol, 0);
    if (fn >= 0) chk({tag, "_first_node_cycle"},  first_node_rel,  fn);
    if (fl >= 0) chk({tag, "_first_leaf_cycle"},  first_leaf_rel,  fl);
    if (fq >= 0) chk({tag, "_first_query_cycle"}, first_query_rel, fq);
    if (dn >= 0) chk({tag, "_done_cycle"}, done_rel, dn);
  endtask

  initial begin
    ntab[0] = '{w0: 11'd3,    w1: 11'd1023, edim: 3'd3, emed: 11'd1023};
    ntab[1] = '{w0: 11'd2047, w1: 11'd0,    edim: 3'd7, emed: 11'd0};
    ntab[2] = '{w0: 11'd8,    w1: 11'd2046, edim: 3'd0, emed: 11'd2046};
    ntab[3] = '{w0: 11'd1021, w1: 11'd1,    edim: 3'd5, emed: 11'd1};
    ltab[0] = '{w: {11'd300, 11'd5, 11'd4, 11'd3, 11'd2, 11'd1},
                epatch: {11'd5, 11'd4, 11'd3, 11'd2, 11'd1}, eidx: 9'd300};
    ltab[1] = '{w: {11'd600, 11'd1024, 11'd0, 11'd2047, 11'd0, 11'd2047},
                epatch: {11'd1024, 11'd0, 11'd2047, 11'd0, 11'd2047}, eidx: 9'd88};
    ltab[2] = '{w: {11'd511, 11'd7, 11'd7, 11'd7, 11'd7, 11'd7},
                epatch: {11'd7, 11'd7, 11'd7, 11'd7, 11'd7}, eidx: 9'd511};
    ltab[3] = '{w: {11'd1536, 11'd0, 11'd0, 11'd0, 11'd0, 11'd0},
                epatch: 55'd0, eidx: 9'd0};

    n_node = 0; n_leaf = 0; n_query = 0; n_done = 0;
    rst = 1'b1; load_kdtree = 1'b0; load_query = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs_in_reset", all_out, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs_idle", all_out, '0);

    build(1'b1);
    run("full", 1'b1, 1'b0, 63, 512, 494, 2, 132, 3203, 5668);

    stall_en = 1'b1;
    build(1'b1);
    run("stall", 1'b1, 1'b0, 63, 512, 494, -1, -1, -1, -1);
    stall_en = 1'b0;

    build(1'b0);
    run("qonly", 1'b0, 1'b1, 0, 0, 494, -1, -1, 5, 2470);

    // Reset after three words of the first leaf patch.
    build(1'b1);
    n_node = 0; n_leaf = 0; n_query = 0; n_done = 0;
    repeat (2) @(negedge clk);
    start_cyc = cyc;
    load_kdtree = 1'b1;
    @(negedge clk);
    load_kdtree = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (popped >= 129) break;
    end
    chk("midrst_words_before", popped, 129);
    chk("midrst_nodes_written", n_node, 63);
    rst = 1'b1;
    #1;
    chk("midrst_outputs_zero", all_out, '0);
    repeat (3) @(negedge clk);
    chk("midrst_outputs_held", all_out, '0);
    rst = 1'b0;
    fifo_q.delete(); exp_node.delete(); exp_leaf.delete(); exp_query.delete();
    repeat (3) @(negedge clk);
    chk("midrst_no_leaf_write", n_leaf, 0);
    chk("midrst_idle_after", busy, 1'b0);

    build(1'b1);
    run("restart", 1'b1, 1'b0, 63, 512, 494, 2, 132, 3203, 5668);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/input_stream_loader.md
Name: input_stream_loader

Overview:
Sits between the input async FIFO read side and the on-chip memories (internal-node regfile, leaf patch SRAMs, query patch SRAM). It pops the serial DATA_WIDTH word stream and deserializes it into node, leaf-patch and query-patch writes with correct addresses. A load_kdtree pulse starts the full sequence: internal nodes, then leaves, then queries. A load_query pulse starts a query-only reload. Asserts load_done when the sequence completes so the main FSM may start.

Parameters:
DATA_WIDTH, 11, stream word width
IDX_WIDTH, 9, patch index width (original-image index)
DIM_WIDTH, 3, split-dimension field width of an internal node
PATCH_SIZE, 5, data words per patch
LEAF_SIZE, 8, patches per leaf
NUM_LEAVES, 64, leaves in tree; NUM_NODES = NUM_LEAVES-1
NUM_QUERYS, 494, query patches per frame
LEAF_ADDRW, $clog2(NUM_LEAVES), leaf address width
QUERY_ADDRW, $clog2(NUM_QUERYS), query address width

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
load_kdtree  in  1  one-cycle start: nodes+leaves+queries
load_query  in  1  one-cycle start: queries only
fifo_rdata  in  DATA_WIDTH  FIFO head word (show-ahead, valid when fifo_rempty_n)
fifo_rempty_n  in  1  FIFO not empty
fifo_deq  out  1  pop head word this cycle
node_wen  out  1  internal-node write strobe
node_waddr  out  LEAF_ADDRW  node address 0..NUM_NODES-1
node_wdim  out  DIM_WIDTH  split dimension
node_wmedian  out  DATA_WIDTH  split median
leaf_wen  out  1  leaf patch write strobe
leaf_waddr  out  LEAF_ADDRW  leaf number
leaf_wsel  out  $clog2(LEAF_SIZE)  patch slot within leaf
leaf_wpatch  out  PATCH_SIZE*DATA_WIDTH  patch, word0 in LSBs
leaf_widx  out  IDX_WIDTH  patch original-image index
query_wen  out  1  query write strobe
query_waddr  out  QUERY_ADDRW  query number
query_wpatch  out  PATCH_SIZE*DATA_WIDTH  query patch, word0 in LSBs
busy  out  1  high in any non-IDLE state
load_done  out  1  one-cycle pulse at end of sequence

Behaviour:
- Reset: state IDLE; all counters 0; every output 0 (strobes, addresses, data, busy, load_done).
- States: IDLE, NODES, LEAVES, QUERIES.
- IDLE: load_kdtree -> NODES; else load_query -> QUERIES. Both high same cycle -> NODES. Starts in any other state ignored.
- fifo_deq = (state != IDLE) & fifo_rempty_n, combinational. A word is consumed exactly in cycles where fifo_deq=1. Empty FIFO mid-stream: stall, counters hold, no writes, no timeout.
- NODES: 2 words per node: word0 -> dim (low DIM_WIDTH bits), word1 -> median. Node write registered one cycle after word1 consumed; address = node counter. After node NUM_NODES-1 -> LEAVES.
- LEAVES: 6 words per patch: 5 data words shifted into patch register, word5 -> index (low IDX_WIDTH bits). Write registered one cycle after word5. leaf_wsel = patch counter 0..LEAF_SIZE-1; wrap increments leaf counter. After leaf NUM_LEAVES-1 slot LEAF_SIZE-1 -> QUERIES (no new start pulse).
- QUERIES: 5 words per query; write registered one cycle after word4; address = query counter. After query NUM_QUERYS-1 -> IDLE; load_done pulses in the same cycle as that final query_wen.
- Strobes one cycle wide; data/address outputs held stable until next write of same type.
- Back-to-back streaming: one write every 2/6/5 cycles at full FIFO rate, no bubbles at section boundaries (first leaf word may be consumed the cycle after last node word).
- Counters clear on every IDLE exit; no wrap beyond limits.
- rst asserted mid-operation: immediate return to IDLE, partial patch discarded, no write strobe; the FIFO is not flushed (owner's responsibility).

Decomposition:
- Package loader_pkg: state enum, NODE_WORDS=2, LEAF_PATCH_WORDS=PATCH_SIZE+1, QUERY_WORDS=PATCH_SIZE, derived widths.
- Sub-module patch_deserializer: PATCH_SIZE-word shift/capture register with word counter, shared by LEAVES and QUERIES paths.
- Top FSM and section counters stay in input_stream_loader.

Test Plan:
- Full load, FIFO always non-empty, 126 node words, 3072 leaf words, 2470 query words -> 63 node_wen, 512 leaf_wen, 494 query_wen, load_done exactly once, count-check and data-check vs source files.
- Node words 3,1023 first -> node_waddr=0, node_wdim=3, node_wmedian=1023, one cycle after second deq.
- Leaf patch words 1,2,3,4,5,300 -> leaf_wpatch words 1..5 in LSB-first order, leaf_widx=300; 9th patch -> leaf_waddr=1, leaf_wsel=0.
- FIFO empty randomly 50% of cycles -> fifo_deq never high while rempty_n=0; identical write sequence to the no-stall run.
- load_query alone with 2470 words -> only query_wen (0..493), load_done on final write; load_kdtree pulsed while busy -> ignored.
- rst pulsed after 3 words of a leaf patch -> all outputs 0, IDLE, no leaf_wen; restart loads cleanly from node 0.
